reg_pipe: RTL and testbench

//   Parametrised elastic pipeline register: DEPTH stages of WIDTH-bit data, each with a valid bit.

---
 rtl/reg_pipe.sv | 94 +++++++++
 tb/tb_reg_pipe.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_pipe.sv
// Elastic valid/ready pipeline register: depth stages of width-bit data with bubble collapse.
// Optional occupancy counter port `occ` is built when REG_PIPE_OCC_EN is defined.
module reg_pipe #(
    parameter int unsigned width = 8,
    parameter int unsigned depth = 2
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             clr,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [width-1:0] din,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [width-1:0] dout
`ifdef REG_PIPE_OCC_EN
    ,
    output logic [$clog2(depth+1)-1:0] occ
`endif
);

    logic [depth-1:0] v;
    logic [width-1:0] d     [depth];
    logic [depth:0]   rdy;
    logic [depth-1:0] src_v;
    logic [width-1:0] src_d [depth];

    // Ready chain runs from the output back to the input; an empty stage is always ready.
    always_comb begin
        rdy        = '0;
        rdy[depth] = out_ready;
        for (int i = int'(depth) - 1; i >= 0; i--) begin
            rdy[i] = !v[i] | rdy[i+1];
        end
    end

    always_comb begin
        src_v    = '0;
        src_v[0] = in_valid;
        src_d[0] = din;
        for (int i = 1; i < int'(depth); i++) begin
            src_v[i] = v[i-1];
            src_d[i] = d[i-1];
        end
    end

    assign in_ready  = rdy[0] & !clr;
    assign out_valid = v[depth-1] & !clr;
    assign dout      = d[depth-1];

    // Data only moves when the source is valid, so empty stages keep their last value.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            v <= '0;
            for (int i = 0; i < int'(depth); i++) begin
                d[i] <= '0;
            end
        end else if (clr) begin
            v <= '0;
        end else begin
            for (int i = 0; i < int'(depth); i++) begin
                if (rdy[i]) begin
                    v[i] <= src_v[i];
                    if (src_v[i]) begin
                        d[i] <= src_d[i];
                    end
                end
            end
        end
    end

`ifdef REG_PIPE_OCC_EN
    localparam int unsigned OCC_W = $clog2(depth + 1);

    logic in_fire;
    logic out_fire;

    assign in_fire  = in_valid & in_ready;
    assign out_fire = out_valid & out_ready;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            occ <= '0;
        end else if (clr) begin
            occ <= '0;
        end else if (in_fire && !out_fire) begin
            occ <= occ + OCC_W'(1);
        end else if (out_fire && !in_fire) begin
            occ <= occ - OCC_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_reg_pipe.sv
// Scoreboard bench for reg_pipe: directed vectors on a depth-3 pipe, random traffic on depth-1.
// Occupancy checks are compiled in when REG_PIPE_OCC_EN is defined.
module tb_reg_pipe;

    logic       clk = 1'b0;
    logic       rstn;
    logic       clr;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] din;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] dout;

    logic       clr1;
    logic       in_valid1;
    logic       in_ready1;
    logic [7:0] din1;
    logic       out_valid1;
    logic       out_ready1;
    logic [7:0] dout1;

`ifdef REG_PIPE_OCC_EN
    logic [1:0] occ;
    logic [0:0] occ1;
`endif

    int errors = 0;
    int checks = 0;

    logic [7:0] q  [$];
    logic [7:0] q1 [$];

    always #5 clk = ~clk;

    reg_pipe #(.width(8), .depth(3)) u_dut (
        .clk       (clk),
        .rstn      (rstn),
        .clr       (clr),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .din       (din),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .dout      (dout)
`ifdef REG_PIPE_OCC_EN
        ,
        .occ       (occ)
`endif
    );

    reg_pipe #(.width(8), .depth(1)) u_dut1 (
        .clk       (clk),
        .rstn      (rstn),
        .clr       (clr1),
        .in_valid  (in_valid1),
        .in_ready  (in_ready1),
        .din       (din1),
        .out_valid (out_valid1),
        .out_ready (out_ready1),
        .dout      (dout1)
`ifdef REG_PIPE_OCC_EN
        ,
        .occ       (occ1)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Depth-3 scoreboard: expected words enter on input handshake, leave on output handshake.
    always @(negedge clk) begin
        if (!rstn) begin
            q.delete();
        end else begin
`ifdef REG_PIPE_OCC_EN
            chk("occ_track", 32'(occ), 32'(q.size()));
`endif
            if (clr) begin
                chk("clr_out_valid", 32'(out_valid), 32'd0);
                q.delete();
            end else begin
                if (out_valid) begin
                    if (q.size() == 0) begin
                        chk("spurious_out", 32'(out_valid), 32'd0);
                    end else begin
                        chk("dout_order", 32'(dout), 32'(q[0]));
                        if (out_ready) void'(q.pop_front());
                    end
                end
                if (in_valid && in_ready) q.push_back(din);
            end
        end
    end

    // Depth-1 scoreboard.
    always @(negedge clk) begin
        if (!rstn) begin
            q1.delete();
        end else begin
`ifdef REG_PIPE_OCC_EN
            chk("occ1_track", 32'(occ1), 32'(q1.size()));
`endif
            if (out_valid1) begin
                if (q1.size() == 0) begin
                    chk("spurious_out1", 32'(out_valid1), 32'd0);
                end else begin
                    chk("dout1_order", 32'(dout1), 32'(q1[0]));
                    if (out_ready1) void'(q1.pop_front());
                end
            end
            if (in_valid1 && in_ready1) q1.push_back(din1);
        end
    end

    // Present a word and hold it until accepted; reports how many cycles it stalled.
    task automatic send(input logic [7:0] x, output int stalls);
        stalls   = 0;
        in_valid = 1'b1;
        din      = x;
        @(negedge clk);
        while (!in_ready && stalls < 50) begin
            @(negedge clk);
            stalls++;
        end
        if (!in_ready) chk("send_timeout", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        out_ready = 1'b1;
        @(negedge clk);
        while ((q.size() != 0 || out_valid) && n < 30) begin
            @(negedge clk);
            n++;
        end
        chk("drain_empty", 32'(q.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    initial begin
        int n;
        rstn = 1'b0; clr = 1'b0; in_valid = 1'b0; din = 8'h00; out_ready = 1'b0;
        clr1 = 1'b0; in_valid1 = 1'b0; din1 = 8'h00; out_ready1 = 1'b0;

        // Reset values, then release mid-cycle.
        repeat (2) @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_dout", 32'(dout), 32'h00);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
`ifdef REG_PIPE_OCC_EN
        chk("rst_occ", 32'(occ), 32'd0);
`endif
        #3 rstn = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("post_rst_out_valid", 32'(out_valid), 32'd0);
        end
        @(posedge clk); #1;

        // Latency into an empty pipe, then a stream with out_ready high.
        out_ready = 1'b1;
        send(8'h01, n);
        @(negedge clk); chk("lat_e0", 32'(out_valid), 32'd0);
        @(negedge clk); chk("lat_e1", 32'(out_valid), 32'd0);
        @(negedge clk); chk("lat_e2_valid", 32'(out_valid), 32'd1);
        chk("lat_e2_dout", 32'(dout), 32'h01);
        for (int k = 2; k <= 16; k++) begin
            send(8'(k), n);
            chk("stream_in_ready", 32'(n), 32'd0);
        end
        drain();

        // Fill with out_ready low; fourth word waits upstream.
        out_ready = 1'b0;
        send(8'hA1, n);
        send(8'hA2, n);
        send(8'hA3, n);
        in_valid = 1'b1; din = 8'hA4;
        repeat (2) begin
            @(negedge clk);
            chk("full_in_ready", 32'(in_ready), 32'd0);
            chk("full_dout", 32'(dout), 32'hA1);
`ifdef REG_PIPE_OCC_EN
            chk("full_occ", 32'(occ), 32'd3);
`endif
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        send(8'hA4, n);
        drain();

        // Bubbles compact while the output stalls.
        out_ready = 1'b0;
        send(8'hB1, n);
        @(posedge clk); #1;
        send(8'hB2, n);
        @(posedge clk); #1;
        @(negedge clk);
        chk("bubble_out_valid", 32'(out_valid), 32'd1);
        chk("bubble_dout", 32'(dout), 32'hB1);
        chk("bubble_in_ready", 32'(in_ready), 32'd1);
`ifdef REG_PIPE_OCC_EN
        chk("bubble_occ", 32'(occ), 32'd2);
`endif
        @(posedge clk); #1;

        // Flush with a word offered and downstream ready.
        clr = 1'b1; in_valid = 1'b1; din = 8'hC1; out_ready = 1'b1;
        @(negedge clk);
        chk("clr_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk); #1;
        clr = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        chk("post_clr_out_valid", 32'(out_valid), 32'd0);
        chk("post_clr_in_ready", 32'(in_ready), 32'd1);
`ifdef REG_PIPE_OCC_EN
        chk("post_clr_occ", 32'(occ), 32'd0);
`endif
        @(posedge clk); #1;
        send(8'hC2, n);
        drain();

        // Asynchronous reset with words in flight.
        out_ready = 1'b0;
        send(8'hD1, n);
        send(8'hD2, n);
        #2 rstn = 1'b0;
        #1;
        chk("arst_out_valid", 32'(out_valid), 32'd0);
        chk("arst_dout", 32'(dout), 32'h00);
        chk("arst_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        @(posedge clk); #1;
        rstn = 1'b1;
        send(8'hE1, n);
        drain();

        // Random traffic on the single-stage pipe.
        for (int c = 0; c < 10000; c++) begin
            @(posedge clk); #1;
            in_valid1  = 1'($urandom_range(0, 1));
            din1       = 8'($urandom);
            out_ready1 = 1'($urandom_range(0, 1));
        end
        @(posedge clk); #1;
        in_valid1 = 1'b0; out_ready1 = 1'b1;
        repeat (3) @(negedge clk);
        chk("rand_drain", 32'(q1.size()), 32'd0);
        chk("final_drain", 32'(q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
